aes_tround: RTL and testbench

Iterative AES encryption round engine built on the registered T-table lookup boxes. It sits directly downstream of the Te0..Te3 boxes: it drives their byte indices, combines their 32-bit outputs with round-key words to form each new state column, and sequences the rounds of one 128-bit block. Key expansion and the four Te box instances are external; this block owns the state register, ShiftRows indexing, round/column counters and the block handshake.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_tround_colmix.sv | 21 ++
 rtl/aes_tround.sv | 166 ++++++++++++++++
 tb/tb_aes_tround.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the iterative AES T-table round engine.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tround_state_e;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Column c of a 128-bit block; column 0 sits in the top word.
  function automatic logic [31:0] col_word(input logic [127:0] blk, input logic [1:0] c);
    return blk[{~c, 5'h1f} -: 32];
  endfunction

  // Plain S-box byte of each Te lane, already in ShiftRows row order.
  function automatic logic [31:0] sbox_lanes(input logic [31:0] q0, input logic [31:0] q1,
                                             input logic [31:0] q2, input logic [31:0] q3);
    return {q0[23:16], q1[15:8], q2[7:0], q3[31:24]};
  endfunction

  function automatic logic [3:0] nr_from_sel(input logic [1:0] sel);
    logic [3:0] nr;
    case (sel)
      2'd0:    nr = 4'(NR_128);
      2'd1:    nr = 4'(NR_192);
      default: nr = 4'(NR_256);
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_tround_colmix.sv
// One output column: Te lane XOR (MixColumns rounds) or S-byte select (final round), plus round key.
module aes_tround_colmix
  import aes_pkg::*;
(
  input  logic [31:0] te_q0,
  input  logic [31:0] te_q1,
  input  logic [31:0] te_q2,
  input  logic [31:0] te_q3,
  input  logic [31:0] rk_word,
  input  logic        final_rnd,
  output logic [31:0] col
);

  always_comb begin
    col = te_q0 ^ te_q1 ^ te_q2 ^ te_q3 ^ rk_word;
    if (final_rnd) begin
      col = sbox_lanes(te_q0, te_q1, te_q2, te_q3) ^ rk_word;
    end
  end

endmodule

// File: rtl/aes_tround.sv
// Iterative AES encryption round engine driving external registered Te0..Te3 boxes.
// Defining AES_TROUND_NR_EN adds the nr_sel port for per-block round-count selection.
//
// state    | meaning
// ST_IDLE  | in_ready=1, waiting for a block; round-0 AddRoundKey on accept
// ST_ISSUE | drive Te indices for column col_q, capture column col_q-1
// ST_DRAIN | capture column 3, commit state, next round or finish
// ST_DONE  | out_valid=1 until out_ready
module aes_tround
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_TROUND_NR_EN
  input  logic [1:0]   nr_sel,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_round,
  input  logic [127:0] rk_key,
  output logic [7:0]   te_idx0,
  output logic [7:0]   te_idx1,
  output logic [7:0]   te_idx2,
  output logic [7:0]   te_idx3,
  input  logic [31:0]  te_q0,
  input  logic [31:0]  te_q1,
  input  logic [31:0]  te_q2,
  input  logic [31:0]  te_q3
);

  tround_state_e state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [1:0]    col_q, col_d;
  logic [127:0]  blk_q, blk_d;
  logic [95:0]   nxt_q, nxt_d;
  logic [127:0]  out_q, out_d;
  logic [3:0]    nr_cur;
  logic [1:0]    cap_col;
  logic [31:0]   rk_word;
  logic [31:0]   col_res;
  logic          final_rnd;
  logic [7:0]    te_idx_a [4];

`ifdef AES_TROUND_NR_EN
  logic [3:0] nr_q, nr_d;

  always_comb begin
    nr_d = nr_q;
    if (state_q == ST_IDLE && in_valid) begin
      nr_d = nr_from_sel(nr_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nr_q <= 4'(NR_128);
    else        nr_q <= nr_d;
  end

  assign nr_cur = nr_q;
`else
  assign nr_cur = 4'(NR);
`endif

  // Column being captured lags the issued column by one cycle (Te box latency).
  assign cap_col   = (state_q == ST_DRAIN) ? 2'd3 : col_q - 2'd1;
  assign rk_word   = col_word(rk_key, cap_col);
  assign final_rnd = (round_q == nr_cur);

  aes_tround_colmix u_colmix (
    .te_q0     (te_q0),
    .te_q1     (te_q1),
    .te_q2     (te_q2),
    .te_q3     (te_q3),
    .rk_word   (rk_word),
    .final_rnd (final_rnd),
    .col       (col_res)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    col_d   = col_q;
    blk_d   = blk_q;
    nxt_d   = nxt_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d   = in_data ^ rk_key;
          round_d = 4'd1;
          col_d   = 2'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        case (col_q)
          2'd1:    nxt_d[95:64] = col_res;
          2'd2:    nxt_d[63:32] = col_res;
          2'd3:    nxt_d[31:0]  = col_res;
          default: nxt_d        = nxt_q;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        blk_d = {nxt_q, col_res};
        col_d = 2'd0;
        if (round_q < nr_cur) begin
          round_d = round_q + 4'd1;
          state_d = ST_ISSUE;
        end else begin
          out_d   = {nxt_q, col_res};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ShiftRows: row r of column c reads from column (c+r) mod 4.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      te_idx_a[r] = 8'd0;
      if (state_q == ST_ISSUE) begin
        te_idx_a[r] = 8'(col_word(blk_q, col_q + 2'(r)) >> (24 - 8 * r));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
      col_q   <= 2'd0;
      blk_q   <= '0;
      nxt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      col_q   <= col_d;
      blk_q   <= blk_d;
      nxt_q   <= nxt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign rk_round  = (state_q == ST_IDLE) ? 4'd0 : round_q;
  assign out_data  = out_q;
  assign te_idx0   = te_idx_a[0];
  assign te_idx1   = te_idx_a[1];
  assign te_idx2   = te_idx_a[2];
  assign te_idx3   = te_idx_a[3];

endmodule

// File: tb/tb_aes_tround.sv
// Directed bench for aes_tround: models registered Te boxes and key expansion, checks FIPS-197 vectors.
module tb_aes_tround;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   rk_round;
  logic [127:0] rk_key;
  logic [7:0]   te_idx0, te_idx1, te_idx2, te_idx3;
  logic [31:0]  te_q0 = '0, te_q1 = '0, te_q2 = '0, te_q3 = '0;
`ifdef AES_TROUND_NR_EN
  logic [1:0]   nr_sel;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc  = 0;
  int lat;
  logic [127:0] held;

  logic [7:0]   sb [256];
  logic [127:0] rks [16];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_tround dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_TROUND_NR_EN
    .nr_sel    (nr_sel),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rk_round  (rk_round),
    .rk_key    (rk_key),
    .te_idx0   (te_idx0),
    .te_idx1   (te_idx1),
    .te_idx2   (te_idx2),
    .te_idx3   (te_idx3),
    .te_q0     (te_q0),
    .te_q1     (te_q1),
    .te_q2     (te_q2),
    .te_q3     (te_q3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] te(input int lane, input logic [7:0] a);
    logic [7:0] s, s2, s3;
    logic [31:0] t;
    s  = sb[a];
    s2 = xt(s);
    s3 = s2 ^ s;
    t  = {s2, s, s, s3};
    return (t >> (8 * lane)) | (t << (32 - 8 * lane));
  endfunction

  // External Te boxes: registered, one-cycle latency.
  always @(posedge clk) begin
    te_q0 <= te(0, te_idx0);
    te_q1 <= te(1, te_idx1);
    te_q2 <= te(2, te_idx2);
    te_q3 <= te(3, te_idx3);
  end

  assign rk_key = rks[rk_round];

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int total;
    total = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rks[r] = '0;
    for (int r = 0; r < nk + 7; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt);
    in_valid = 1'b1;
    in_data  = pt;
    step();
    t_acc    = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int l);
    l = -1;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        l = cyc - t_acc;
        break;
      end
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef AES_TROUND_NR_EN
    nr_sel    = 2'd0;
`endif
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    for (int r = 0; r < 16; r++) rks[r] = '0;

    #3;
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data",  out_data,        128'd0);
    chk("rst_rk_round",  128'(rk_round),  128'd0);
    chk("rst_te_idx",    128'({te_idx0, te_idx1, te_idx2, te_idx3}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // FIPS-197 App. B with backpressure
    expand({KEY_B, 128'h0}, 4);
    send(PT_B);
    chk("b_accepted", 128'(in_ready), 128'd0);
    wait_out(200, lat);
    chk("b_latency", 128'(lat), 128'd50);
    chk("b_data",    out_data,  CT_B);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_data",     out_data,        CT_B);
      chk("bp_in_ready", 128'(in_ready),  128'd0);
      chk("bp_valid",    128'(out_valid), 128'd1);
    end
    chk("bp_rk_round", 128'(rk_round), 128'd10);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", 128'(in_ready),  128'd1);
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_rk",    128'(rk_round),  128'd0);

    // FIPS-197 C.1 with rk_round trace
    expand({KEY_1, 128'h0}, 4);
    chk("c1_rk_idle", 128'(rk_round), 128'd0);
    send(PT_1);
    for (int k = 0; k <= 50; k++) begin
      chk("c1_valid_rk", 128'({out_valid, rk_round}),
          128'({k == 50, (k < 50) ? 4'(1 + k / 5) : 4'd10}));
      if (k < 50) step();
    end
    chk("c1_data", out_data, CT_1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Back-to-back blocks with in_valid held
    in_valid  = 1'b1;
    in_data   = PT_1;
    out_ready = 1'b1;
    step();
    t_acc = cyc;
    wait_out(200, lat);
    chk("b2b_lat1",  128'(lat), 128'd50);
    chk("b2b_data1", out_data,  CT_1);
    step();
    chk("b2b_idle", 128'(in_ready), 128'd1);
    step();
    t_acc    = cyc;
    in_valid = 1'b0;
    chk("b2b_accept2", 128'({in_ready, rk_round}), 128'({1'b0, 4'd1}));
    wait_out(200, lat);
    chk("b2b_lat2",  128'(lat), 128'd50);
    chk("b2b_data2", out_data,  CT_1);
    step();
    out_ready = 1'b0;
    chk("b2b_idle2", 128'(in_ready), 128'd1);

    // Reset at round 4 column 2
    send(PT_1);
    for (int k = 0; k < 17; k++) step();
    chk("mid_rk_round", 128'(rk_round), 128'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_ready", 128'(in_ready),  128'd1);
    chk("mid_rst_rk",    128'(rk_round),  128'd0);
    chk("mid_rst_data",  out_data,        128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(PT_1);
    wait_out(200, lat);
    chk("post_rst_lat",  128'(lat), 128'd50);
    chk("post_rst_data", out_data,  CT_1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

`ifdef AES_TROUND_NR_EN
    // FIPS-197 C.3, 14 rounds selected per block
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    nr_sel = 2'd2;
    send(PT_1);
    nr_sel = 2'd0;
    wait_out(300, lat);
    chk("c3_lat",  128'(lat),      128'd70);
    chk("c3_data", out_data,       128'h8ea2b7ca516745bfeafc49904b496089);
    chk("c3_rk",   128'(rk_round), 128'd14);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
